spi_slave_gen2: RTL

//  Parametrised SPI slave; generalises the 8-bit, system-clocked-by-SCLK slave.

---
 rtl/spi_slave_gen2_if.sv | 32 +++
 rtl/spi_slave_gen2.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_gen2_if.sv
// rtl/spi_slave_gen2_if.sv - pin, TX-load and RX-handshake bundle for spi_slave_gen2
interface spi_slave_gen2_if #(
  parameter int DATA_W = 8
);
  logic              enable;
  logic              load;
  logic [DATA_W-1:0] inload;
  logic [1:0]        Mode;
  logic              lsb_first;
  logic              SCLK;
  logic              SS;
  logic              MOSI;
  logic              MISO;
  logic [DATA_W-1:0] Slave_SR;
  logic              Slave_Done;
  logic              busy;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              overrun;
  logic              frame_err;

  modport slave (
    input  enable, load, inload, Mode, lsb_first, SCLK, SS, MOSI, rx_ready,
    output MISO, Slave_SR, Slave_Done, busy, rx_data, rx_valid, overrun, frame_err
  );

  modport master (
    output enable, load, inload, Mode, lsb_first, SCLK, SS, MOSI, rx_ready,
    input  MISO, Slave_SR, Slave_Done, busy, rx_data, rx_valid, overrun, frame_err
  );
endinterface

// File: rtl/spi_slave_gen2.sv
// rtl/spi_slave_gen2.sv - oversampling SPI slave, all modes, MSB/LSB first; SPI_SLAVE_RXFIFO_EN selects RX FIFO
module spi_slave_gen2 #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input logic            clk,
  input logic            reset,
  spi_slave_gen2_if.slave bus
);
  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic                   sclk_d, ss_d;
  logic                   sclk_s, ss_s, mosi_s;
  logic                   cpol, cpha, lsb;
  logic [CW-1:0]          cnt;
  logic [DATA_W-1:0]      tx_sr, tx_hold, slave_sr, tx_src;
  logic                   miso_bit, done, ferr, busy_r;
  logic                   rise, fall, lead, trail, sample_edge, shift_edge;
  logic                   ss_fall, ss_rise, push;
  logic [DATA_W-1:0]      rx_data_o;
  logic                   rx_valid_o, overrun_o;

  // Next bit to put on MISO from a TX shift register, given the bit order.
  function automatic logic first_bit(input logic [DATA_W-1:0] v, input logic l);
    return l ? v[0] : v[DATA_W-1];
  endfunction

  // TX shift register after one bit has been presented.
  function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] v, input logic l);
    return l ? {1'b0, v[DATA_W-1:1]} : {v[DATA_W-2:0], 1'b0};
  endfunction

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // SS synchroniser resets low so that SS held low through reset never looks like a fresh fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= '0;
      ss_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.SCLK};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.SS};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.MOSI};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
    end
  end

  // Leading edge moves SCLK away from its idle (CPOL) level; CPHA picks which edge samples.
  always_comb begin
    rise        = sclk_s & ~sclk_d;
    fall        = ~sclk_s & sclk_d;
    lead        = cpol ? fall : rise;
    trail       = cpol ? rise : fall;
    sample_edge = (cpha ? trail : lead) & bus.enable;
    shift_edge  = (cpha ? lead : trail) & bus.enable;
    ss_fall     = ss_d & ~ss_s;
    ss_rise     = ~ss_d & ss_s;
    tx_src      = bus.load ? bus.inload : tx_sr;
  end

  // Frame FSM: mode capture, bit shifting, word completion and frame-error detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cpol     <= 1'b0;
      cpha     <= 1'b0;
      lsb      <= 1'b0;
      cnt      <= '0;
      tx_sr    <= '0;
      tx_hold  <= '0;
      slave_sr <= '0;
      miso_bit <= 1'b0;
      done     <= 1'b0;
      ferr     <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      done <= 1'b0;
      ferr <= 1'b0;
      case (state)
        IDLE: begin
          busy_r <= 1'b0;
          if (bus.load) begin
            tx_sr   <= bus.inload;
            tx_hold <= bus.inload;
          end
          if (ss_fall && bus.enable) begin
            cpol   <= bus.Mode[1];
            cpha   <= bus.Mode[0];
            lsb    <= bus.lsb_first;
            cnt    <= '0;
            state  <= ACTIVE;
            busy_r <= 1'b1;
            // CPHA=0 must present bit 0 before the first (sampling) edge arrives.
            if (!bus.Mode[0]) begin
              miso_bit <= first_bit(tx_src, bus.lsb_first);
              tx_sr    <= tx_shift(tx_src, bus.lsb_first);
            end else begin
              miso_bit <= 1'b0;
            end
          end
        end
        ACTIVE: begin
          if (bus.load) tx_hold <= bus.inload;
          if (done) begin
            cnt <= '0;
            if (!cpha) begin
              miso_bit <= first_bit(tx_hold, lsb);
              tx_sr    <= tx_shift(tx_hold, lsb);
            end else begin
              tx_sr <= tx_hold;
            end
          end
          if (ss_rise) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            if (!done && cnt != '0) ferr <= 1'b1;
          end else if (!done) begin
            if (sample_edge) begin
              slave_sr <= lsb ? {mosi_s, slave_sr[DATA_W-1:1]} : {slave_sr[DATA_W-2:0], mosi_s};
              cnt      <= cnt + CW'(1);
              if (cnt == CW'(DATA_W - 1)) done <= 1'b1;
            end
            // With CPHA=0 the trailing edge that follows the last sample belongs to the
            // finished word; the next word's bit 0 is already on MISO, so skip it.
            if (shift_edge && (cpha || cnt != '0)) begin
              miso_bit <= first_bit(tx_sr, lsb);
              tx_sr    <= tx_shift(tx_sr, lsb);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign push = done;

`ifdef SPI_SLAVE_RXFIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              empty, full, pop, accept;

  always_comb begin
    empty  = (wr_ptr == rd_ptr);
    full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop    = !empty && bus.rx_ready;
    accept = push && (!full || pop);
  end

  // FIFO pointers; a pop in the same cycle frees room for a push into a full FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overrun_o <= 1'b0;
    end else begin
      overrun_o <= push && full && !pop;
      if (accept) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)    rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // FIFO storage, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= slave_sr;
  end

  assign rx_valid_o = !empty;
  assign rx_data_o  = empty ? '0 : mem[rd_ptr[AW-1:0]];
`else
  // Single holding register: a new word always replaces the old one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (push) begin
        rx_data_o  <= slave_sr;
        rx_valid_o <= 1'b1;
        if (rx_valid_o && !bus.rx_ready) overrun_o <= 1'b1;
      end else if (rx_valid_o && bus.rx_ready) begin
        rx_valid_o <= 1'b0;
      end
    end
  end
`endif

  assign bus.MISO       = (state == ACTIVE) && bus.enable && miso_bit;
  assign bus.Slave_SR   = slave_sr;
  assign bus.Slave_Done = done;
  assign bus.busy       = busy_r;
  assign bus.frame_err  = ferr;
  assign bus.rx_data    = rx_data_o;
  assign bus.rx_valid   = rx_valid_o;
  assign bus.overrun    = overrun_o;
endmodule
